// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus observer: detects START/RESTART/STOP, assembles 9-bit byte
// frames and queues one 11-bit record per event in a first-word-fall-through FIFO.
`timescale 1ns/1ps
module i2c_bus_monitor #(
    parameter int FIFO_DEPTH_LOG = 3,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    SCL,
    input  logic                    SDA,
    input  logic                    rd_en,
    input  logic                    overflow_clr,
    output logic [10:0]             rec_data,
    output logic                    rec_valid,
    output logic [FIFO_DEPTH_LOG:0] fifo_level,
    output logic                    bus_busy,
    output logic                    overflow
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG;
    localparam logic [FIFO_DEPTH_LOG:0] FULL_LEVEL = {1'b1, {FIFO_DEPTH_LOG{1'b0}}};

    localparam logic [1:0] T_START   = 2'b00;
    localparam logic [1:0] T_RESTART = 2'b01;
    localparam logic [1:0] T_BYTE    = 2'b10;
    localparam logic [1:0] T_STOP    = 2'b11;

    typedef enum logic {S_IDLE = 1'b0, S_ACTIVE = 1'b1} state_t;

    logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
    logic                   scl_prev, sda_prev;
    logic                   scl_cur, sda_cur;
    logic                   start_q, stop_q, rise_q, sda_q;
    state_t                 state, next_state;
    logic [3:0]             bit_cnt;
    logic [7:0]             shift_q;
    logic                   push;
    logic [10:0]            push_rec;

    assign scl_cur = scl_sync[SYNC_STAGES-1];
    assign sda_cur = sda_sync[SYNC_STAGES-1];

    // Synchronizers idle high so reset release never looks like a bus edge.
    // NOTE: sequential state is assigned with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], SCL};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], SDA};
            scl_prev <= scl_cur;
            sda_prev <= sda_cur;
        end
    end

    // Registered conditions: an SDA change while SCL moves is neither START nor STOP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            rise_q  <= 1'b0;
            sda_q   <= 1'b1;
        end else begin
            start_q <= scl_prev & scl_cur & sda_prev & ~sda_cur;
            stop_q  <= scl_prev & scl_cur & ~sda_prev & sda_cur;
            rise_q  <= ~scl_prev & scl_cur;
            sda_q   <= sda_cur;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= next_state;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start_q) next_state = S_ACTIVE;
            S_ACTIVE: if (stop_q)  next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    always_comb begin
        push     = 1'b0;
        push_rec = '0;
        case (state)
            S_IDLE: begin
                if (start_q) begin
                    push     = 1'b1;
                    push_rec = {T_START, 9'b0};
                end
            end
            S_ACTIVE: begin
                if (start_q) begin
                    push     = 1'b1;
                    push_rec = {T_RESTART, 9'b0};
                end else if (stop_q) begin
                    push     = 1'b1;
                    push_rec = {T_STOP, 4'b0, bit_cnt, 1'b0};
                end else if (rise_q && bit_cnt == 4'd8) begin
                    push     = 1'b1;
                    push_rec = {T_BYTE, shift_q, ~sda_q};
                end
            end
            default: ;
        endcase
    end

    assign bus_busy = (state == S_ACTIVE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bit_cnt <= '0;
            shift_q <= '0;
        end else if (start_q || stop_q) begin
            bit_cnt <= '0;
        end else if (state == S_ACTIVE && rise_q) begin
            if (bit_cnt == 4'd8) begin
                bit_cnt <= '0;
            end else begin
                shift_q <= {shift_q[6:0], sda_q};
                bit_cnt <= bit_cnt + 4'd1;
            end
        end
    end

    logic [10:0]               mem [DEPTH];
    logic [FIFO_DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic [FIFO_DEPTH_LOG:0]   count;
    logic                      full, pop, wr_en, drop;

    assign full  = (count == FULL_LEVEL);
    assign pop   = rd_en && rec_valid;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    // NOTE: storage is not reset; rec_data is masked to zero whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_rec;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)              overflow <= 1'b0;
        else if (drop)         overflow <= 1'b1;
        else if (overflow_clr) overflow <= 1'b0;
    end

    assign rec_valid  = (count != '0);
    assign fifo_level = count;
    assign rec_data   = rec_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_i2c_bus_monitor.sv
// Self-checking bench for i2c_bus_monitor: a bus-level event model predicts
// records and FIFO state each cycle; hand-computed records pin the model.
`timescale 1ns/1ps
module tb_i2c_bus_monitor;

    localparam int LOG   = 3;
    localparam int SYNC  = 2;
    localparam int DEPTH = 1 << LOG;
    localparam int LAT   = SYNC + 2;  // drive after edge E -> record at edge E+LAT
    localparam int H     = 4;         // cycles per bus phase

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          scl = 1'b1;
    logic          sda = 1'b1;
    logic          rd_en = 1'b0;
    logic          overflow_clr = 1'b0;
    logic [10:0]   rec_data;
    logic          rec_valid;
    logic [LOG:0]  fifo_level;
    logic          bus_busy;
    logic          overflow;

    i2c_bus_monitor #(.FIFO_DEPTH_LOG(LOG), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst(rst), .SCL(scl), .SDA(sda), .rd_en(rd_en),
        .overflow_clr(overflow_clr), .rec_data(rec_data), .rec_valid(rec_valid),
        .fifo_level(fifo_level), .bus_busy(bus_busy), .overflow(overflow)
    );

    always #10 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit chk_en = 1'b0;

    typedef struct {
        int          due;
        logic [10:0] rec;
        bit          busy;
    } ev_t;

    ev_t         pend[$];
    logic [10:0] mq[$];
    bit          m_busy, m_ovf;
    bit          b_scl = 1'b1, b_sda = 1'b1, b_active = 1'b0;
    int          b_cnt = 0;
    logic [7:0]  b_sh = '0;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Interpret one bus-level change using the protocol rules directly.
    function automatic void model_bus(bit nscl, bit nsda);
        ev_t e;
        e.due  = cyc + LAT;
        e.busy = b_active;
        e.rec  = '0;
        if (b_scl && nscl && b_sda && !nsda) begin
            e.rec  = b_active ? 11'h200 : 11'h000;
            e.busy = 1'b1;
            b_active = 1'b1;
            b_cnt    = 0;
            pend.push_back(e);
        end else if (b_scl && nscl && !b_sda && nsda) begin
            if (b_active) begin
                e.rec  = {2'b11, 4'b0, 4'(b_cnt), 1'b0};
                e.busy = 1'b0;
                pend.push_back(e);
            end
            b_active = 1'b0;
            b_cnt    = 0;
        end else if (!b_scl && nscl && b_active) begin
            if (b_cnt < 8) begin
                b_sh  = {b_sh[6:0], nsda};
                b_cnt = b_cnt + 1;
            end else begin
                e.rec = {2'b10, b_sh, ~nsda};
                pend.push_back(e);
                b_cnt = 0;
            end
        end
        b_scl = nscl;
        b_sda = nsda;
    endfunction

    // Model of the record queue, advanced once per clock edge.
    initial begin : model_proc
        ev_t e;
        bit  pop, full, drop;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                pop  = rd_en && (mq.size() > 0);
                full = (mq.size() == DEPTH);
                drop = 1'b0;
                if (pop) void'(mq.pop_front());
                while (pend.size() > 0 && pend[0].due <= cyc) begin
                    e = pend.pop_front();
                    m_busy = e.busy;
                    if (full && !pop) drop = 1'b1;
                    else              mq.push_back(e.rec);
                end
                if (drop)              m_ovf = 1'b1;
                else if (overflow_clr) m_ovf = 1'b0;
            end
        end
    end

    initial begin : compare_proc
        forever begin
            @(negedge clk);
            if (chk_en && rst) begin
                check("cmp rec_valid", rec_valid, mq.size() != 0);
                check("cmp fifo_level", fifo_level, mq.size());
                if (mq.size() != 0) check("cmp rec_data", rec_data, mq[0]);
                check("cmp bus_busy", bus_busy, m_busy);
                check("cmp overflow", overflow, m_ovf);
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    task automatic drive(bit nscl, bit nsda);
        @(posedge clk);
        #1;
        scl = nscl;
        sda = nsda;
        model_bus(nscl, nsda);
        repeat (H - 1) @(posedge clk);
    endtask

    task automatic settle();
        repeat (LAT + 4) @(posedge clk);
    endtask

    task automatic start_cond();
        if (scl && !sda) drive(1'b0, 1'b0);
        if (!scl) begin
            drive(1'b0, 1'b1);
            drive(1'b1, 1'b1);
        end
        drive(1'b1, 1'b0);
        drive(1'b0, 1'b0);
    endtask

    task automatic stop_cond();
        if (scl && !sda) begin
            drive(1'b1, 1'b1);
        end else begin
            if (scl) drive(1'b0, sda);
            drive(1'b0, 1'b0);
            drive(1'b1, 1'b0);
            drive(1'b1, 1'b1);
        end
    endtask

    task automatic send_bit(bit v);
        if (scl) drive(1'b0, sda);
        drive(1'b0, v);
        drive(1'b1, v);
        drive(1'b0, v);
    endtask

    // Eight data bits MSB first, then the ACK bit; SCL is left high afterwards.
    task automatic send_byte(logic [7:0] b, bit ack_low, int stretch);
        for (int i = 7; i >= 0; i--) begin
            send_bit(b[i]);
            if (i == 4 && stretch > 0) repeat (stretch) @(posedge clk);
        end
        drive(1'b0, !ack_low);
        drive(1'b1, !ack_low);
    endtask

    task automatic pop_check(string name, logic [10:0] exp);
        @(negedge clk);
        check({name, " valid"}, rec_valid, 1'b1);
        check(name, rec_data, exp);
        @(posedge clk);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic drain();
        @(posedge clk);
        #1 rd_en = 1'b1;
        repeat (DEPTH + 2) @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic do_reset(bit pin);
        @(negedge clk);
        chk_en = 1'b0;
        rst = 1'b0;
        scl = 1'b1;
        sda = 1'b1;
        rd_en = 1'b0;
        overflow_clr = 1'b0;
        mq.delete();
        pend.delete();
        m_busy = 1'b0;
        m_ovf  = 1'b0;
        b_scl = 1'b1; b_sda = 1'b1; b_active = 1'b0; b_cnt = 0; b_sh = '0;
        #1;
        if (pin) begin
            check("rst rec_data", rec_data, 11'h000);
            check("rst rec_valid", rec_valid, 1'b0);
            check("rst fifo_level", fifo_level, 0);
            check("rst bus_busy", bus_busy, 1'b0);
            check("rst overflow", overflow, 1'b0);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        chk_en = 1'b1;
    endtask

    initial begin
        do_reset(1'b1);

        // Write transaction: 0x8E ACK, 0x5A ACK, STOP in the ACK high phase.
        start_cond();
        @(negedge clk);
        check("write busy", bus_busy, 1'b1);
        send_byte(8'h8E, 1'b1, 0);
        send_byte(8'h5A, 1'b1, 0);
        stop_cond();
        settle();
        @(negedge clk);
        check("write idle", bus_busy, 1'b0);
        check("write level", fifo_level, 4);
        pop_check("write start", 11'h000);
        pop_check("write byte0", 11'h51D);
        pop_check("write byte1", 11'h4B5);
        pop_check("write stop", 11'h600);

        // Read with final NACK; STOP follows one extra SCL rise.
        start_cond();
        send_byte(8'h9F, 1'b1, 0);
        send_byte(8'hDC, 1'b1, 0);
        send_byte(8'hFF, 1'b0, 0);
        stop_cond();
        settle();
        pop_check("read start", 11'h000);
        pop_check("read addr", 11'h53F);
        pop_check("read dc", 11'h5B9);
        pop_check("read ff nack", 11'h5FE);
        pop_check("read stop", 11'h602);

        // Repeated START after three data bits.
        start_cond();
        send_bit(1'b1);
        send_bit(1'b0);
        start_cond();
        send_byte(8'h8F, 1'b1, 0);
        stop_cond();
        settle();
        pop_check("rs start", 11'h000);
        pop_check("rs restart", 11'h200);
        pop_check("rs byte", 11'h51F);
        pop_check("rs stop", 11'h600);

        // Overflow: ten START/STOP records with no reads.
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0);
            drive(1'b1, 1'b1);
        end
        settle();
        @(negedge clk);
        check("ovf level", fifo_level, 8);
        check("ovf flag", overflow, 1'b1);
        for (int i = 0; i < 8; i++) pop_check("ovf rec", (i % 2) ? 11'h600 : 11'h000);
        @(posedge clk);
        #1 overflow_clr = 1'b1;
        @(posedge clk);
        #1 overflow_clr = 1'b0;
        @(negedge clk);
        check("ovf cleared", overflow, 1'b0);

        // Fill to eight, then pop in the very cycle of the ninth push.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0);
            drive(1'b1, 1'b1);
        end
        drive(1'b1, 1'b0);
        #1 rd_en = 1'b1;
        @(posedge clk);
        #1 rd_en = 1'b0;
        settle();
        @(negedge clk);
        check("full pop level", fifo_level, 8);
        check("full pop flag", overflow, 1'b0);
        drain();
        drive(1'b1, 1'b1);
        settle();
        drain();

        // Reset after five bits of a byte, then a clean transaction.
        start_cond();
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        @(negedge clk);
        check("pre-rst valid", rec_valid, 1'b1);
        check("pre-rst busy", bus_busy, 1'b1);
        do_reset(1'b1);
        settle();
        @(negedge clk);
        check("post-rst level", fifo_level, 0);
        start_cond();
        send_byte(8'h3C, 1'b1, 0);
        stop_cond();
        settle();
        pop_check("clean start", 11'h000);
        pop_check("clean byte", 11'h479);
        pop_check("clean stop", 11'h600);

        // Stretched SCL low phase mid-byte, then a stray STOP while idle.
        start_cond();
        send_byte(8'hA5, 1'b1, 400);
        stop_cond();
        settle();
        pop_check("stretch start", 11'h000);
        pop_check("stretch byte", 11'h54B);
        pop_check("stretch stop", 11'h600);
        drive(1'b0, 1'b1);
        drive(1'b0, 1'b0);
        drive(1'b1, 1'b0);
        drive(1'b1, 1'b1);
        settle();
        @(negedge clk);
        check("stray stop level", fifo_level, 0);
        check("stray stop busy", bus_busy, 1'b0);

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
